ca_gen_param: RTL and testbench
===============================

Name: ca_gen_param

Overview:
- Parametrised successor to the fixed 16-bit, 64-word elementary cellular-automaton line generator.
- Reads the current generation (one row of cells) from one bank of the dual-port line RAM and computes the next generation.
- Writes the result to the other bank, one word per cycle.
- Adds a runtime-selectable Wolfram rule, start/busy/done handshake, a generation counter and optional toroidal wrap.

Parameters:
- DATA_W, 16, cells per RAM word.
- WORDS, 64, words per row; row length = DATA_W*WORDS cells; WORDS >= 2.
- ADDR_W, 8, RAM address width; must be >= clog2(2*WORDS).
- CNT_W, 16, width of gen_count.

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to compute one generation; honoured only when busy=0.
- direction  in  1  0: read bank 0, write bank 1; 1: read bank 1, write bank 0. Sampled with start.
- rule  in  8  Wolfram rule number. Sampled with start.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  one-cycle pulse after the last word is written.
- read  out  1  RAM read enable.
- raddr  out  ADDR_W  read address = bank*WORDS + word index.
- rdata  in  DATA_W  RAM read data; valid exactly 1 clk after read.
- write  out  1  RAM write enable (registered).
- waddr  out  ADDR_W  write address (registered).
- wdata  out  DATA_W  write data (registered).
- gen_count  out  CNT_W  completed generations; wraps modulo 2^CNT_W.

Behaviour:
- Reset values: all outputs 0; state IDLE; gen_count 0. Reset mid-operation aborts immediately; no further read/write; a partially written bank is acceptable.
- Cell order:
  - Bit b of word k is cell k*DATA_W+b; cell 0 is leftmost.
  - Neighbours of cell i are i-1 (left) and i+1 (right).
  - New cell = rule[{left,centre,right}], 3-bit index, left = MSB.
- States:
  - IDLE: start=1 latches direction and rule, then goes to PRE if wrap is enabled, else STREAM.
  - PRE: reads word WORDS-1 to capture its bit DATA_W-1 as the left neighbour of cell 0.
  - STREAM: reads words 0..WORDS-1 on consecutive cycles, then goes to FLUSH.
  - FLUSH: computes the last word using the right boundary, then goes to DONE.
  - DONE: pulses done, increments gen_count, returns to IDLE.
- Timing, no wrap, start accepted at cycle 0:
  - read word j at cycle j+1.
  - rdata for word j at cycle j+2.
  - Word k is computed when word k+1 data is present, or in FLUSH for k=WORDS-1.
  - write for word k visible at cycle k+4, for k = 0..WORDS-1.
  - done at cycle WORDS+4; busy low at WORDS+5.
- Timing, wrap enabled: every event above is 1 cycle later.
- Boundary cells:
  - Left of cell 0 and right of the last cell are 0 without wrap.
  - With wrap, they are bit DATA_W-1 of word WORDS-1 and bit 0 of word 0; word 0 is held in a register for the end of the row.
- read and write may both be asserted in the same cycle. Source and destination banks differ, so there is no RAM hazard.
- start while busy is ignored: no re-sampling of direction/rule, no restart.
- start in the DONE cycle is ignored.
- start in the first IDLE cycle after done is accepted, so back-to-back generations are spaced WORDS+5 (+1 with wrap) cycles.
- raddr and waddr upper bits above clog2(2*WORDS) are 0.

Optional Feature:
- Macro CA_GEN_WRAP_EN.
- Defined: toroidal boundary, adds the PRE state and the held word-0 register; all timing shifted by +1 cycle.
- Undefined: zero boundary; no PRE state, no word-0 register.

Decomposition:
- Package ca_pkg:
  - state enum (IDLE, PRE, STREAM, FLUSH, DONE).
  - rule constants RULE_30=8'd30, RULE_90=8'd90, RULE_110=8'd110.
  - clog2 helper function.
- Sub-module ca_word_step: purely combinational next-generation of one word from (left_bit, word[DATA_W], right_bit, rule).

Test Plan:
- DATA_W=16, WORDS=4, no wrap, rule 90, bank0 = {0,0,0x0001,0} (cell 32 set), direction 0 -> bank1 = {0,0x8000,0x0002,0}; writes at cycles 4..7; done at cycle 8; gen_count=1.
- Same with CA_GEN_WRAP_EN, rule 90, bank0 word0=0x0001 only -> bank1 word0=0x0002, word3=0x8000; without the macro word3=0x0000.
- direction 1, rule 204 (identity), bank1 = {0x1234,0xABCD,0x0F0F,0xFFFF} -> reads at addr 4..7; writes at addr 0..3 with identical data.
- start pulsed again at cycle 2 with rule 0 -> ignored; output still matches the original rule; only one done pulse.
- rst_n low at cycle 3 of a generation -> next cycle read=write=busy=0, state IDLE, gen_count 0; a fresh start then completes normally.
- 3 back-to-back generations with rule 30, starts issued on the cycle after each done -> gen_count=3; each result matches the software model.

Source files
------------

// File: rtl/ca_pkg.sv
// Shared types, rule constants and elaboration helpers for the cellular-automaton line generator.
package ca_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        STREAM,
        FLUSH,
        DONE
    } state_t;

    typedef logic [7:0] rule_t;

    localparam rule_t RULE_30  = 8'd30;
    localparam rule_t RULE_90  = 8'd90;
    localparam rule_t RULE_110 = 8'd110;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ca_word_step.sv
// Next generation of one word of cells; bit 0 is the leftmost cell of the word.
module ca_word_step
    import ca_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              left_bit,
    input  logic [DATA_W-1:0] word,
    input  logic              right_bit,
    input  rule_t             rule,
    output logic [DATA_W-1:0] next_word
);

    // padded[b] is the left neighbour of cell b, padded[b+2] its right neighbour.
    logic [DATA_W+1:0] padded;
    assign padded = {right_bit, word, left_bit};

    always_comb begin
        // NOTE: default the whole output first so no bit can infer a latch.
        next_word = '0;
        for (int b = 0; b < DATA_W; b++) begin
            next_word[b] = rule[{padded[b], padded[b+1], padded[b+2]}];
        end
    end

endmodule

// File: rtl/ca_gen_param.sv
// Elementary cellular-automaton line generator: streams one bank of the line RAM through a rule
// into the other bank. Define CA_GEN_WRAP_EN for a toroidal row (adds the PRE read of the last word).
module ca_gen_param
    import ca_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int WORDS  = 64,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              direction,
    input  logic [7:0]        rule,
    output logic              busy,
    output logic              done,
    output logic              read,
    output logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rdata,
    output logic              write,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic [CNT_W-1:0]  gen_count
);

    localparam int              IDX_W    = clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t            state;
    logic              rbank;
    rule_t             rule_q;
    logic [IDX_W-1:0]  rd_word;
    logic              rd_pre;
    logic              rvalid;
    logic [IDX_W-1:0]  rv_word;
    logic              rv_pre;
    logic              last_wr;
    logic [DATA_W-1:0] cur_word;
    logic              left_bit;
    logic              right_edge;
    logic              step_right;
    logic [DATA_W-1:0] next_word;

`ifdef CA_GEN_WRAP_EN
    logic word0_lsb;
    assign right_edge = word0_lsb;
`else
    assign right_edge = 1'b0;
`endif

    // The word being finished sees the head of the next word, except in FLUSH where the row ends.
    assign step_right = (state == FLUSH) ? right_edge : rdata[0];

    ca_word_step #(.DATA_W(DATA_W)) u_step (
        .left_bit  (left_bit),
        .word      (cur_word),
        .right_bit (step_right),
        .rule      (rule_q),
        .next_word (next_word)
    );

    function automatic logic [ADDR_W-1:0] bank_addr(input logic bank, input logic [IDX_W-1:0] idx);
        return (bank ? ADDR_W'(WORDS) : ADDR_W'(0)) + ADDR_W'(idx);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            read      <= 1'b0;
            raddr     <= '0;
            write     <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            gen_count <= '0;
            rbank     <= 1'b0;
            rule_q    <= '0;
            rd_word   <= '0;
            rd_pre    <= 1'b0;
            rvalid    <= 1'b0;
            rv_word   <= '0;
            rv_pre    <= 1'b0;
            last_wr   <= 1'b0;
            cur_word  <= '0;
            left_bit  <= 1'b0;
`ifdef CA_GEN_WRAP_EN
            word0_lsb <= 1'b0;
`endif
        end else begin
            // NOTE: all state here uses <= so every read below sees the pre-edge value.
            write   <= 1'b0;
            done    <= 1'b0;
            rvalid  <= read;
            rv_word <= rd_word;
            rv_pre  <= rd_pre;

            // Word k is emitted once word k+1 arrives, carrying the left neighbour forward.
            if (rvalid) begin
                if (rv_pre) begin
                    left_bit <= rdata[DATA_W-1];
                end else begin
                    cur_word <= rdata;
                    if (rv_word == '0) begin
`ifdef CA_GEN_WRAP_EN
                        word0_lsb <= rdata[0];
`endif
                    end else begin
                        write    <= 1'b1;
                        waddr    <= bank_addr(!rbank, rv_word - IDX_W'(1));
                        wdata    <= next_word;
                        left_bit <= cur_word[DATA_W-1];
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        rbank    <= direction;
                        rule_q   <= rule;
                        busy     <= 1'b1;
                        read     <= 1'b1;
                        left_bit <= 1'b0;
                        last_wr  <= 1'b0;
`ifdef CA_GEN_WRAP_EN
                        state    <= PRE;
                        rd_pre   <= 1'b1;
                        rd_word  <= LAST_IDX;
                        raddr    <= bank_addr(direction, LAST_IDX);
`else
                        state    <= STREAM;
                        rd_pre   <= 1'b0;
                        rd_word  <= '0;
                        raddr    <= bank_addr(direction, '0);
`endif
                    end
                end
`ifdef CA_GEN_WRAP_EN
                PRE: begin
                    state   <= STREAM;
                    rd_pre  <= 1'b0;
                    rd_word <= '0;
                    raddr   <= bank_addr(rbank, '0);
                end
`endif
                STREAM: begin
                    if (read) begin
                        if (rd_word == LAST_IDX) begin
                            read <= 1'b0;
                        end else begin
                            rd_word <= rd_word + IDX_W'(1);
                            raddr   <= bank_addr(rbank, rd_word + IDX_W'(1));
                        end
                    end else if (rvalid) begin
                        state <= FLUSH;
                    end
                end
                // Two cycles: emit the last word, then let its write land before signalling done.
                FLUSH: begin
                    if (!last_wr) begin
                        write   <= 1'b1;
                        waddr   <= bank_addr(!rbank, LAST_IDX);
                        wdata   <= next_word;
                        last_wr <= 1'b1;
                    end else begin
                        state     <= DONE;
                        done      <= 1'b1;
                        gen_count <= gen_count + CNT_W'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ca_gen_param.sv
// Directed bench for ca_gen_param with a 4-word row and a behavioural line RAM.
module tb_ca_gen_param;
    import ca_pkg::*;

    localparam int DATA_W = 16;
    localparam int WORDS  = 4;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 16;
`ifdef CA_GEN_WRAP_EN
    localparam int LAT  = 1;
    localparam bit WRAP = 1'b1;
`else
    localparam int LAT  = 0;
    localparam bit WRAP = 1'b0;
`endif
    localparam int DONE_CYC = WORDS + 4 + LAT;
    localparam int NCYC     = DONE_CYC + 4;

    localparam logic [63:0] ROW_A   = 64'h0000_0001_0000_0000;
    localparam logic [63:0] ROW_A90 = 64'h0000_0002_8000_0000;
    localparam logic [63:0] ROW_DEAD = {4{16'hDEAD}};

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              direction = 1'b0;
    logic [7:0]        rule = 8'd0;
    logic              busy, done, read, write;
    logic [ADDR_W-1:0] raddr, waddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata = '0;
    logic [CNT_W-1:0]  gen_count;

    logic [15:0] mem [0:7];
    logic        ld_en = 1'b0;
    logic [2:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;

    logic        c_read  [NCYC];
    logic [7:0]  c_raddr [NCYC];
    logic        c_write [NCYC];
    logic [7:0]  c_waddr [NCYC];
    logic [15:0] c_wdata [NCYC];
    logic        c_done  [NCYC];
    logic        c_busy  [NCYC];

    int passed = 0;
    int total = 0;
    int exp_gen = 0;

    ca_gen_param #(.DATA_W(DATA_W), .WORDS(WORDS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .direction(direction), .rule(rule),
        .busy(busy), .done(done), .read(read), .raddr(raddr), .rdata(rdata),
        .write(write), .waddr(waddr), .wdata(wdata), .gen_count(gen_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (read) rdata <= mem[raddr[2:0]];
        if (write) mem[waddr[2:0]] <= wdata;
        if (ld_en) mem[ld_addr] <= ld_data;
    end

    function automatic logic [63:0] bank_row(input int b);
        return {mem[b*4+3], mem[b*4+2], mem[b*4+1], mem[b*4]};
    endfunction

    // Cell-by-cell reference: cell i is bit i of the row.
    function automatic logic [63:0] model_row(input logic [63:0] cells, input logic [7:0] r);
        logic [63:0] nxt;
        logic l, rr;
        for (int i = 0; i < 64; i++) begin
            if (i == 0) l = WRAP ? cells[63] : 1'b0;
            else        l = cells[i-1];
            if (i == 63) rr = WRAP ? cells[0] : 1'b0;
            else         rr = cells[i+1];
            nxt[i] = r[{l, cells[i], rr}];
        end
        return nxt;
    endfunction

    task automatic load_bank(input int b, input logic [63:0] row);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ld_en = 1'b1;
            ld_addr = 3'(b * 4 + k);
            ld_data = row[k*16 +: 16];
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Cycle 0 carries start; alt_cyc (if >= 1) pulses a second start with alt_rule and flipped direction.
    task automatic run_gen(input logic dir, input logic [7:0] r, input int alt_cyc,
                           input logic [7:0] alt_rule, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            c_read[c] = read;   c_raddr[c] = raddr;
            c_write[c] = write; c_waddr[c] = waddr; c_wdata[c] = wdata;
            c_done[c] = done;   c_busy[c] = busy;
            if (c == 0) begin
                start = 1'b1; direction = dir; rule = r;
            end else if (c == alt_cyc) begin
                start = 1'b1; direction = ~dir; rule = alt_rule;
            end else begin
                start = 1'b0; direction = dir; rule = r;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        total++; if ({busy, done, read, write} !== 4'b0) $display("FAIL reset_ctrl: got %b want 0000", {busy, done, read, write}); else passed++;
        total++; if (raddr !== 8'd0) $display("FAIL reset_raddr: got %0h want 0", raddr); else passed++;
        total++; if (waddr !== 8'd0) $display("FAIL reset_waddr: got %0h want 0", waddr); else passed++;
        total++; if (wdata !== 16'd0) $display("FAIL reset_wdata: got %0h want 0", wdata); else passed++;
        total++; if (gen_count !== 16'd0) $display("FAIL reset_gen_count: got %0d want 0", gen_count); else passed++;
    endtask

    task automatic test_rule90;
        int n;
        load_bank(0, ROW_A);
        load_bank(1, ROW_DEAD);
        run_gen(1'b0, RULE_90, -1, 8'd0, NCYC);
        exp_gen++;
        total++; if ({c_read[1], c_raddr[1]} !== {1'b1, (WRAP ? 8'd3 : 8'd0)}) $display("FAIL r90_first_read: got %b/%0d want 1/%0d", c_read[1], c_raddr[1], WRAP ? 3 : 0); else passed++;
        for (int j = 0; j < WORDS; j++) begin
            total++; if ({c_read[j+1+LAT], c_raddr[j+1+LAT]} !== {1'b1, 8'(j)}) $display("FAIL r90_read%0d: got %b/%0d want 1/%0d", j, c_read[j+1+LAT], c_raddr[j+1+LAT], j); else passed++;
        end
        total++; if (c_read[WORDS+1+LAT] !== 1'b0) $display("FAIL r90_read_stop: got %b want 0", c_read[WORDS+1+LAT]); else passed++;
        total++; if (c_write[3+LAT] !== 1'b0) $display("FAIL r90_early_write: got %b want 0", c_write[3+LAT]); else passed++;
        for (int k = 0; k < WORDS; k++) begin
            total++;
            if ({c_write[k+4+LAT], c_waddr[k+4+LAT], c_wdata[k+4+LAT]} !== {1'b1, 8'(4+k), ROW_A90[k*16 +: 16]})
                $display("FAIL r90_write%0d: got %b/%0d/%h want 1/%0d/%h", k, c_write[k+4+LAT], c_waddr[k+4+LAT], c_wdata[k+4+LAT], 4+k, ROW_A90[k*16 +: 16]);
            else passed++;
        end
        total++; if (c_write[DONE_CYC] !== 1'b0) $display("FAIL r90_late_write: got %b want 0", c_write[DONE_CYC]); else passed++;
        n = 0;
        for (int c = 0; c < NCYC; c++) if (c_done[c] === 1'b1) n++;
        total++; if (c_done[DONE_CYC] !== 1'b1 || n != 1) $display("FAIL r90_done: got %b count %0d want 1 count 1", c_done[DONE_CYC], n); else passed++;
        total++; if ({c_busy[0], c_busy[1], c_busy[DONE_CYC], c_busy[DONE_CYC+1]} !== 4'b0110) $display("FAIL r90_busy: got %b want 0110", {c_busy[0], c_busy[1], c_busy[DONE_CYC], c_busy[DONE_CYC+1]}); else passed++;
        total++; if (bank_row(1) !== ROW_A90) $display("FAIL r90_bank1: got %h want %h", bank_row(1), ROW_A90); else passed++;
        total++; if (gen_count !== 16'(exp_gen)) $display("FAIL r90_gen_count: got %0d want %0d", gen_count, exp_gen); else passed++;
    endtask

    task automatic test_wrap;
        logic [63:0] exp_row;
        exp_row = WRAP ? 64'h8000_0000_0000_0002 : 64'h0000_0000_0000_0002;
        load_bank(0, 64'h0000_0000_0000_0001);
        load_bank(1, ROW_DEAD);
        run_gen(1'b0, RULE_90, -1, 8'd0, NCYC);
        exp_gen++;
        for (int k = 0; k < WORDS; k++) begin
            total++; if (mem[4+k] !== exp_row[k*16 +: 16]) $display("FAIL wrap_word%0d: got %h want %h", k, mem[4+k], exp_row[k*16 +: 16]); else passed++;
        end
        total++; if (c_done[DONE_CYC] !== 1'b1) $display("FAIL wrap_done: got %b want 1", c_done[DONE_CYC]); else passed++;
    endtask

    task automatic test_direction;
        logic [63:0] src;
        src = 64'hFFFF_0F0F_ABCD_1234;
        load_bank(0, 64'h0);
        load_bank(1, src);
        run_gen(1'b1, 8'd204, -1, 8'd0, NCYC);
        exp_gen++;
        total++; if (c_raddr[1] !== (WRAP ? 8'd7 : 8'd4)) $display("FAIL dir_first_raddr: got %0d want %0d", c_raddr[1], WRAP ? 7 : 4); else passed++;
        for (int j = 0; j < WORDS; j++) begin
            total++; if ({c_read[j+1+LAT], c_raddr[j+1+LAT]} !== {1'b1, 8'(4+j)}) $display("FAIL dir_read%0d: got %b/%0d want 1/%0d", j, c_read[j+1+LAT], c_raddr[j+1+LAT], 4+j); else passed++;
            total++;
            if ({c_write[j+4+LAT], c_waddr[j+4+LAT], c_wdata[j+4+LAT]} !== {1'b1, 8'(j), src[j*16 +: 16]})
                $display("FAIL dir_write%0d: got %b/%0d/%h want 1/%0d/%h", j, c_write[j+4+LAT], c_waddr[j+4+LAT], c_wdata[j+4+LAT], j, src[j*16 +: 16]);
            else passed++;
        end
        total++; if (bank_row(0) !== src) $display("FAIL dir_bank0: got %h want %h", bank_row(0), src); else passed++;
    endtask

    task automatic test_ignored_start;
        int n;
        load_bank(0, ROW_A);
        load_bank(1, ROW_DEAD);
        run_gen(1'b0, RULE_90, 2, 8'd0, NCYC);
        exp_gen++;
        n = 0;
        for (int c = 0; c < NCYC; c++) if (c_done[c] === 1'b1) n++;
        total++; if (c_raddr[3] !== 8'(2 - LAT)) $display("FAIL ign_raddr: got %0d want %0d", c_raddr[3], 2 - LAT); else passed++;
        total++; if (bank_row(1) !== ROW_A90) $display("FAIL ign_bank1: got %h want %h", bank_row(1), ROW_A90); else passed++;
        total++; if (c_done[DONE_CYC] !== 1'b1 || n != 1) $display("FAIL ign_done: got %b count %0d want 1 count 1", c_done[DONE_CYC], n); else passed++;
        total++; if (c_busy[NCYC-1] !== 1'b0) $display("FAIL ign_restart: busy got %b want 0", c_busy[NCYC-1]); else passed++;
        total++; if (gen_count !== 16'(exp_gen)) $display("FAIL ign_gen_count: got %0d want %0d", gen_count, exp_gen); else passed++;
    endtask

    task automatic test_reset_abort;
        load_bank(0, ROW_A);
        load_bank(1, ROW_DEAD);
        @(negedge clk); start = 1'b1; direction = 1'b0; rule = RULE_90;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_gen = 0;
        total++; if ({read, write, busy, done} !== 4'b0) $display("FAIL abort_ctrl: got %b want 0000", {read, write, busy, done}); else passed++;
        total++; if (gen_count !== 16'd0) $display("FAIL abort_gen_count: got %0d want 0", gen_count); else passed++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        total++; if ({read, write, busy} !== 3'b0) $display("FAIL abort_quiet: got %b want 000", {read, write, busy}); else passed++;
        load_bank(1, ROW_DEAD);
        run_gen(1'b0, RULE_90, -1, 8'd0, NCYC);
        exp_gen++;
        total++; if (bank_row(1) !== ROW_A90) $display("FAIL abort_rerun_bank1: got %h want %h", bank_row(1), ROW_A90); else passed++;
        total++; if (c_done[DONE_CYC] !== 1'b1) $display("FAIL abort_rerun_done: got %b want 1", c_done[DONE_CYC]); else passed++;
        total++; if (gen_count !== 16'(exp_gen)) $display("FAIL abort_rerun_gen_count: got %0d want %0d", gen_count, exp_gen); else passed++;
    endtask

    task automatic test_back_to_back;
        logic [63:0] row;
        logic [63:0] exp_row;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        exp_gen = 0;
        row = ROW_A;
        load_bank(0, row);
        load_bank(1, 64'h0);
        for (int g = 0; g < 3; g++) begin
            run_gen(1'(g % 2), RULE_30, -1, 8'd0, DONE_CYC + 1);
            exp_gen++;
            exp_row = model_row(row, RULE_30);
            total++; if (bank_row(1 - (g % 2)) !== exp_row) $display("FAIL b2b_gen%0d_row: got %h want %h", g, bank_row(1 - (g % 2)), exp_row); else passed++;
            total++; if ({c_busy[0], c_done[DONE_CYC]} !== 2'b01) $display("FAIL b2b_gen%0d_timing: got busy0=%b done=%b want 0/1", g, c_busy[0], c_done[DONE_CYC]); else passed++;
            row = exp_row;
        end
        total++; if (gen_count !== 16'd3) $display("FAIL b2b_gen_count: got %0d want 3", gen_count); else passed++;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_rule90();
        test_wrap();
        test_direction();
        test_ignored_start();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
